serializer_16to2: RTL and testbench



---
 rtl/serializer_pkg.sv | 19 +
 rtl/serializer_16to2.sv | 83 ++++++++
 tb/tb_serializer_16to2.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared sizing for the word-to-symbol serializer: default widths and helpers
// that derive the beat count and beat-counter width from the word geometry.
package serializer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OUT_W_DEF  = 2;

    // Number of symbols per word; guarded so a bad OUT_W never divides by zero.
    function automatic int calc_beats(input int data_w, input int out_w);
        return (out_w > 0) ? (data_w / out_w) : 1;
    endfunction

    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int CNT_W_DEF = calc_cnt_w(calc_beats(DATA_W_DEF, OUT_W_DEF));

endpackage

// File: rtl/serializer_16to2.sv
// Parallel-to-serial converter: a load strobe captures a word, which then leaves
// as BEATS consecutive OUT_W-bit symbols with a registered valid flag.
module serializer_16to2
    import serializer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [DATA_W-1:0] p_in,
    output logic [OUT_W-1:0]  s_out,
    output logic              data_valid
);

    localparam int BEATS = calc_beats(DATA_W, OUT_W);
    localparam int CNT_W = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((OUT_W < 1) || ((DATA_W % OUT_W) != 0)) begin : g_param_check
        $error("serializer_16to2: DATA_W must be a positive multiple of OUT_W");
    end

    logic [DATA_W-1:0] sh_r;
    logic [DATA_W-1:0] sh_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [OUT_W-1:0]  sym_nxt_s;
    logic              valid_nxt_s;

    // Next-state: a load always wins and restarts the word; otherwise drain sh.
    always_comb begin
        sh_nxt_s    = sh_r;
        cnt_nxt_s   = cnt_r;
        sym_nxt_s   = {OUT_W{1'b0}};
        valid_nxt_s = 1'b0;
        if (load_en) begin
            valid_nxt_s = 1'b1;
            cnt_nxt_s   = CNT_LAST;
            if (MSB_FIRST) begin
                sym_nxt_s = p_in[DATA_W-1 -: OUT_W];
                sh_nxt_s  = p_in << OUT_W;
            end else begin
                sym_nxt_s = p_in[OUT_W-1:0];
                sh_nxt_s  = p_in >> OUT_W;
            end
        end else if (data_valid && (cnt_r != CNT_ZERO)) begin
            valid_nxt_s = 1'b1;
            cnt_nxt_s   = cnt_r - CNT_ONE;
            if (MSB_FIRST) begin
                sym_nxt_s = sh_r[DATA_W-1 -: OUT_W];
                sh_nxt_s  = sh_r << OUT_W;
            end else begin
                sym_nxt_s = sh_r[OUT_W-1:0];
                sh_nxt_s  = sh_r >> OUT_W;
            end
        end else begin
            // End of word or idle: outputs return to zero, counter rests at zero.
            valid_nxt_s = 1'b0;
            sym_nxt_s   = {OUT_W{1'b0}};
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r       <= {DATA_W{1'b0}};
            cnt_r      <= CNT_ZERO;
            s_out      <= {OUT_W{1'b0}};
            data_valid <= 1'b0;
        end else begin
            sh_r       <= sh_nxt_s;
            cnt_r      <= cnt_nxt_s;
            s_out      <= sym_nxt_s;
            data_valid <= valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_serializer_16to2.sv
// Self-checking bench: directed spec sequences plus randomized loads and resets,
// compared each cycle against a word/index reference model for both symbol orders.
module tb_serializer_16to2;

    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] p_in = 16'h0000;
    logic [1:0]  s_out_m;
    logic        valid_m;
    logic [1:0]  s_out_l;
    logic        valid_l;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the word in flight, index of the symbol on the output, active flag.
    logic [15:0] word_ref;
    int          k_ref = 0;
    bit          act_ref = 1'b0;

    logic [1:0] tbl_abcd_msb [8] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd3, 2'd1};
    logic [1:0] tbl_abcd_lsb [8] = '{2'd1, 2'd3, 2'd0, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
    logic [1:0] tbl_1234_msb [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};

    serializer_16to2 #(.DATA_W(16), .OUT_W(2), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .p_in(p_in),
        .s_out(s_out_m), .data_valid(valid_m)
    );

    serializer_16to2 #(.DATA_W(16), .OUT_W(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .p_in(p_in),
        .s_out(s_out_l), .data_valid(valid_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_sym(input bit msb);
        int shamt;
        if (!act_ref) return 2'b00;
        shamt = msb ? 2 * (BEATS - 1 - k_ref) : 2 * k_ref;
        return 2'((word_ref >> shamt) & 16'h0003);
    endfunction

    task automatic model_edge(input logic ld, input logic [15:0] d);
        if (ld) begin
            word_ref = d;
            k_ref    = 0;
            act_ref  = 1'b1;
        end else if (act_ref) begin
            k_ref++;
            if (k_ref == BEATS) begin
                act_ref = 1'b0;
                k_ref   = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("msb_sym",   {30'd0, s_out_m}, {30'd0, exp_sym(1'b1)});
        check("msb_valid", {31'd0, valid_m}, {31'd0, act_ref});
        check("lsb_sym",   {30'd0, s_out_l}, {30'd0, exp_sym(1'b0)});
        check("lsb_valid", {31'd0, valid_l}, {31'd0, act_ref});
    endtask

    task automatic tick(input logic ld, input logic [15:0] d);
        load_en = ld;
        p_in    = d;
        @(posedge clk);
        model_edge(ld, d);
        #1;
        compare_all();
    endtask

    // Drops rst_n between edges and expects outputs to clear before any clock.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        act_ref = 1'b0;
        k_ref   = 0;
        check("rst_async_msb", {29'd0, s_out_m, valid_m}, 32'd0);
        check("rst_async_lsb", {29'd0, s_out_l, valid_l}, 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held for two edges with load_en toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_en = ~load_en;
            p_in    = 16'hABCD;
            @(posedge clk);
            #1;
            check("rst_hold", {27'd0, s_out_m, valid_m, s_out_l, valid_l}, 32'd0);
        end
        load_en = 1'b0;
        #2;
        rst_n = 1'b1;

        // Single word in both orders, then return to idle.
        tick(1'b1, 16'hABCD);
        check("abcd_msb_0", {30'd0, s_out_m}, {30'd0, tbl_abcd_msb[0]});
        check("abcd_lsb_0", {30'd0, s_out_l}, {30'd0, tbl_abcd_lsb[0]});
        for (int i = 1; i < BEATS; i++) begin
            tick(1'b0, 16'h0000);
            check("abcd_msb", {30'd0, s_out_m}, {30'd0, tbl_abcd_msb[i]});
            check("abcd_lsb", {30'd0, s_out_l}, {30'd0, tbl_abcd_lsb[i]});
        end
        tick(1'b0, 16'h0000);
        check("abcd_end", {29'd0, s_out_m, valid_m}, 32'd0);
        tick(1'b0, 16'h5555);

        // Back-to-back: second load on the edge that would end the first word.
        tick(1'b1, 16'hABCD);
        for (int i = 1; i < BEATS; i++) tick(1'b0, 16'h0000);
        tick(1'b1, 16'h1234);
        check("b2b_valid", {31'd0, valid_m}, 32'd1);
        check("b2b_msb_0", {30'd0, s_out_m}, {30'd0, tbl_1234_msb[0]});
        for (int i = 1; i < BEATS; i++) begin
            tick(1'b0, 16'h0000);
            check("b2b_msb", {30'd0, s_out_m}, {30'd0, tbl_1234_msb[i]});
        end
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);

        // Abort after three symbols.
        tick(1'b1, 16'hFFFF);
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);
        tick(1'b1, 16'h0001);
        for (int i = 1; i < BEATS; i++) tick(1'b0, 16'h0000);
        check("abort_last", {30'd0, s_out_m}, 32'd1);
        tick(1'b0, 16'h0000);

        // Reset mid-word after four symbols, then a clean load.
        tick(1'b1, 16'hABCD);
        for (int i = 1; i < 4; i++) tick(1'b0, 16'h0000);
        async_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000);
        tick(1'b1, 16'h1234);
        for (int i = 1; i <= BEATS; i++) tick(1'b0, 16'h0000);

        // Load held high: reloads every edge.
        for (int i = 0; i < 4; i++) tick(1'b1, 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < BEATS + 1; i++) tick(1'b0, 16'h0000);

        // Randomized loads, holds and occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 3) == 0), 16'($urandom));
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
